// File: rtl/iter_div_ctrl.sv
// Multi-cycle radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu.
// Accepts one operation per valid/ready handshake and holds the result until it is consumed or flushed.
module iter_div_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quot,
   output logic [WIDTH-1:0] out_rem,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_nxt;
   logic [WIDTH-1:0] rem_q, rem_nxt;
   logic [WIDTH-1:0] quot_q, quot_nxt;
   logic [WIDTH-1:0] dvs_q, dvs_nxt;
   logic             sgn_quot_q, sgn_quot_nxt;
   logic             sgn_rem_q, sgn_rem_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [WIDTH-1:0] out_quot_nxt, out_rem_nxt;
   logic [WIDTH-1:0] dvd_abs, dvs_abs;
   logic [WIDTH:0]   rem_sh, trial;

   // Operand magnitudes and one restoring step on the partial remainder
   always_comb begin
      dvd_abs = (in_signed && in_dividend[WIDTH-1]) ? ({WIDTH{1'b0}} - in_dividend) : in_dividend;
      dvs_abs = (in_signed && in_divisor[WIDTH-1])  ? ({WIDTH{1'b0}} - in_divisor)  : in_divisor;
      rem_sh  = {rem_q, quot_q[WIDTH-1]};
      trial   = rem_sh - {1'b0, dvs_q};
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt    = state_q;
      rem_nxt      = rem_q;
      quot_nxt     = quot_q;
      dvs_nxt      = dvs_q;
      sgn_quot_nxt = sgn_quot_q;
      sgn_rem_nxt  = sgn_rem_q;
      cnt_nxt      = cnt_q;
      out_quot_nxt = out_quot;
      out_rem_nxt  = out_rem;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               rem_nxt      = {WIDTH{1'b0}};
               quot_nxt     = dvd_abs;
               dvs_nxt      = dvs_abs;
               sgn_quot_nxt = in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
               sgn_rem_nxt  = in_signed & in_dividend[WIDTH-1];
               cnt_nxt      = {CNT_W{1'b0}};
               if (in_divisor == {WIDTH{1'b0}}) begin
                  state_nxt    = DONE;
                  out_quot_nxt = {WIDTH{1'b1}};
                  out_rem_nxt  = in_dividend;
               end else begin
                  state_nxt = CALC;
               end
            end
         end
         CALC: begin
            quot_nxt = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
            rem_nxt  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            cnt_nxt  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_nxt    = DONE;
               out_quot_nxt = sgn_quot_q ? ({WIDTH{1'b0}} - quot_nxt) : quot_nxt;
               out_rem_nxt  = sgn_rem_q  ? ({WIDTH{1'b0}} - rem_nxt)  : rem_nxt;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Flush wins over accept and consume; results only change on entry to DONE
      if (flush) begin
         state_nxt    = IDLE;
         out_quot_nxt = out_quot;
         out_rem_nxt  = out_rem;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_nxt;
   end

   // Datapath and registered status outputs decoded from the next state
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem_q      <= {WIDTH{1'b0}};
         quot_q     <= {WIDTH{1'b0}};
         dvs_q      <= {WIDTH{1'b0}};
         sgn_quot_q <= 1'b0;
         sgn_rem_q  <= 1'b0;
         cnt_q      <= {CNT_W{1'b0}};
         out_quot   <= {WIDTH{1'b0}};
         out_rem    <= {WIDTH{1'b0}};
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
      end else begin
         rem_q      <= rem_nxt;
         quot_q     <= quot_nxt;
         dvs_q      <= dvs_nxt;
         sgn_quot_q <= sgn_quot_nxt;
         sgn_rem_q  <= sgn_rem_nxt;
         cnt_q      <= cnt_nxt;
         out_quot   <= out_quot_nxt;
         out_rem    <= out_rem_nxt;
         out_valid  <= (state_nxt == DONE);
         in_ready   <= (state_nxt == IDLE);
         busy       <= (state_nxt != IDLE);
      end
   end

endmodule

// File: doc/iter_div_ctrl.md
Name: iter_div_ctrl

Overview:
Multi-cycle 32-bit integer divider with its sequencing controller, used by the EXE stage for div.w/mod.w/div.wu/mod.wu in place of vendor divider IP. It accepts one operation through a valid/ready handshake and runs a radix-2 restoring iteration under a small FSM. It holds the quotient and remainder until the stage consumes them, and abandons work on a pipeline flush (exception/ertn).

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  controller can accept (high only in IDLE)
in_signed  input  1  1 = signed (div.w/mod.w), 0 = unsigned
in_dividend  input  WIDTH  rj value
in_divisor  input  WIDTH  rk value
flush  input  1  cancel current/pending operation
out_valid  output  1  result available
out_ready  input  1  consumer takes result this cycle
out_quot  output  WIDTH  quotient
out_rem  output  WIDTH  remainder
busy  output  1  state != IDLE

Behaviour:
- Reset (resetn low, asynchronous): state = IDLE, counter = 0, out_valid = 0, busy = 0, out_quot = 0, out_rem = 0, in_ready = 1 once resetn deasserts.
- States: IDLE, CALC, DONE.
- IDLE: in_ready = 1. On in_valid && !flush, capture operands on the edge.
  - Latch |dividend| and |divisor|, using two's-complement magnitude when in_signed.
  - Latch sign_q = in_signed & (dvd[31]^dvs[31]) and sign_r = in_signed & dvd[31].
  - Next state is CALC with counter = 0.
  - If the divisor is zero, go to DONE instead, with out_quot = all ones and out_rem = raw in_dividend. No sign fix applies.
- CALC: one restoring step per cycle.
  - Shift {rem, quot} left by 1.
  - Compute trial = rem - |divisor| at WIDTH+1 bits.
  - If trial is non-negative, rem = trial and quot LSB = 1; otherwise quot LSB = 0.
  - The counter increments each cycle. After step WIDTH-1, go to DONE.
  - On that transition, register the sign-fixed results: out_quot = sign_q ? -quot : quot, and out_rem = sign_r ? -rem : rem, both mod 2^WIDTH.
- Latency: with the accepting edge as edge 0, out_valid rises after edge WIDTH (32 cycles). For a zero divisor it rises after edge 0 (next cycle).
- DONE: out_valid = 1; out_quot and out_rem stay stable while out_ready = 0.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - There is no accept in the same cycle: in_ready is 0 in DONE.
- Flush: in any state, the next state is IDLE and out_valid goes 0 on the next edge.
  - Flush beats in_valid in IDLE (no capture) and beats out_ready in DONE (result dropped, harmless).
  - Result registers may keep stale values; only out_valid qualifies them.
- Signed overflow 0x80000000 / 0xFFFFFFFF: the magnitude path gives quot = 0x80000000 and rem = 0. With sign_q = 0, out_quot = 0x80000000 and out_rem = 0, with no special case.
- Quotient truncates toward zero. The remainder takes the dividend's sign. The outputs change only on the edge entering DONE and on reset.
- in_* inputs are sampled only on the accept edge; changes during CALC/DONE are ignored.

Test Plan:
- Signed 7 / -2 (0x7, 0xFFFFFFFE) -> after 32 cycles out_quot = 0xFFFFFFFD, out_rem = 0x1; in_ready low for 33 cycles.
- Signed -7 / 2 -> out_quot = 0xFFFFFFFD, out_rem = 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> out_quot = 0x80000000, out_rem = 0.
- Unsigned 0xFFFFFFFF / 0x10 -> out_quot = 0x0FFFFFFF, out_rem = 0xF. Signed 0xFFFFFFFF / 0x10 -> out_quot = 0, out_rem = 0xFFFFFFFF.
- Divide by zero (either mode), dividend 0x1234 -> out_valid one cycle after accept, out_quot = 0xFFFFFFFF, out_rem = 0x1234.
- Hold out_ready = 0 for 5 cycles in DONE -> out_valid and results stable. Raise out_ready -> out_valid 0 next cycle and in_ready 1. Flush at CALC step 10 -> out_valid never rises, in_ready 1 next cycle, back-to-back 100/7 unsigned gives 14 and 2.
- Assert resetn low asynchronously mid-CALC -> outputs return to reset values immediately. Flush and in_valid in the same cycle -> no operation accepted.
